// File: rtl/peaks_pkg.sv
// Shared widths, result record and sequencer state encoding for the peak
// detector front-end.
package peaks_pkg;

    localparam int PEAKS      = 6;
    localparam int FREQ_WIDTH = 9;
    localparam int AMPL_WIDTH = 24;
    localparam int TIME_WIDTH = 16;

    localparam int AMPS_W  = PEAKS * AMPL_WIDTH;
    localparam int FREQS_W = PEAKS * FREQ_WIDTH;

    // 'time' is a keyword, so the time-tag field is called frame_time
    typedef struct packed {
        logic [AMPS_W-1:0]     amps;
        logic [FREQS_W-1:0]    freqs;
        logic [TIME_WIDTH-1:0] frame_time;
    } peak_result_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STROBE_HI = 2'd1,
        SETTLE    = 2'd2,
        CAPTURE   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/peak_result_fifo.sv
// First-word fall-through result buffer. A push into a full buffer only
// succeeds when a pop happens in the same cycle (pop frees the slot first).
module peak_result_fifo
    import peaks_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  peak_result_t din,
    output peak_result_t dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    peak_result_t          mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // storage array, no reset needed since empty gates validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/peaks_sequencer.sv
// Frame sequencer for the peak detector: clean strobe with guaranteed low
// gap, settle wait, capture, priming discard and drop-on-full buffering.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for an FFT frame, fft_ready high
// STROBE_HI | detector valid_in held high for STROBE_HIGH cycles
// SETTLE    | valid_in low for SETTLE cycles while detector settles
// CAPTURE   | one cycle: sample detector outputs, push or discard
//
// The SETTLE parameter hides the imported enum literal of the same name,
// so the state is referenced as peaks_pkg::SETTLE inside this module.
module peaks_sequencer
    import peaks_pkg::*;
#(
    parameter int STROBE_HIGH = 2,
    parameter int SETTLE      = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  fft_valid,
    output logic                  fft_ready,
    output logic                  busy,
    output logic                  pk_strobe,
    output logic                  pk_reset,
    input  logic [AMPS_W-1:0]     pk_amps,
    input  logic [FREQS_W-1:0]    pk_freqs,
    input  logic [TIME_WIDTH-1:0] pk_counter,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AMPS_W-1:0]     out_amps,
    output logic [FREQS_W-1:0]    out_freqs,
    output logic [TIME_WIDTH-1:0] out_time,
    output logic [15:0]           frames_dropped
);

    localparam int TMR_MAX = (STROBE_HIGH > SETTLE) ? STROBE_HIGH : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] STROBE_LOAD = TMR_W'(STROBE_HIGH - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;
    logic             accept;
    logic             capture;
    logic [1:0]       prime_cnt;
    logic             primed;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    peak_result_t     result_in;
    peak_result_t     head;

    // detector restart cycle also blocks new frames
    assign fft_ready = reset && !flush && !pk_reset && (state == IDLE);
    assign accept    = fft_valid && fft_ready;
    assign busy      = reset && (state != IDLE);

    // two results of pipeline priming are thrown away after each restart
    assign primed = (prime_cnt >= 2'd2);
    assign push   = capture && primed;
    assign pop    = out_valid && out_ready;

    // time tag refers to the centre frame of the 3-frame window
    assign result_in.amps       = pk_amps;
    assign result_in.freqs      = pk_freqs;
    assign result_in.frame_time = pk_counter - TIME_WIDTH'(2);

    assign out_valid = reset && !fifo_empty;
    assign out_amps  = reset ? head.amps       : '0;
    assign out_freqs = reset ? head.freqs      : '0;
    assign out_time  = reset ? head.frame_time : '0;

    // next-state and strobe timing; flush overrides everything
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        capture   = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
            tmr_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_nxt = STROBE_HI;
                        tmr_nxt   = STROBE_LOAD;
                    end
                end
                STROBE_HI: begin
                    if (tmr == '0) begin
                        state_nxt = peaks_pkg::SETTLE;
                        tmr_nxt   = SETTLE_LOAD;
                    end else begin
                        tmr_nxt = tmr - 1'b1;
                    end
                end
                peaks_pkg::SETTLE: begin
                    if (tmr == '0) state_nxt = CAPTURE;
                    else           tmr_nxt   = tmr - 1'b1;
                end
                CAPTURE: begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // state register plus glitch-free registered detector strobe/reset
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state     <= IDLE;
            tmr       <= '0;
            pk_strobe <= 1'b0;
            pk_reset  <= 1'b1;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            pk_strobe <= (state_nxt == STROBE_HI);
            pk_reset  <= flush;
        end
    end

    // priming counter, cleared whenever the detector restarts
    always_ff @(posedge CLOCK_50) begin
        if (!reset || flush) begin
            prime_cnt <= '0;
        end else if (capture && !primed) begin
            prime_cnt <= prime_cnt + 1'b1;
        end
    end

    // saturating lost-result counter, survives flush
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            frames_dropped <= '0;
        end else if (push && fifo_full && !pop && (frames_dropped != 16'hFFFF)) begin
            frames_dropped <= frames_dropped + 16'd1;
        end
    end

    peak_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (result_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_peaks_sequencer.sv
// Directed bench for peaks_sequencer: reset, strobe timing, priming,
// data path, overflow/drop, full-with-pop and flush.
module tb_peaks_sequencer;
    import peaks_pkg::*;

    logic                  CLOCK_50 = 1'b0;
    logic                  reset;
    logic                  flush;
    logic                  fft_valid;
    logic                  fft_ready;
    logic                  busy;
    logic                  pk_strobe;
    logic                  pk_reset;
    logic [AMPS_W-1:0]     pk_amps;
    logic [FREQS_W-1:0]    pk_freqs;
    logic [TIME_WIDTH-1:0] pk_counter;
    logic                  out_valid;
    logic                  out_ready;
    logic [AMPS_W-1:0]     out_amps;
    logic [FREQS_W-1:0]    out_freqs;
    logic [TIME_WIDTH-1:0] out_time;
    logic [15:0]           frames_dropped;

    localparam logic [AMPS_W-1:0]  AMPS_VEC  = {24'd10, 24'd9, 24'd8, 24'd7, 24'd6, 24'd5};
    localparam logic [FREQS_W-1:0] FREQS_VEC = {9'd300, 9'd200, 9'd120, 9'd80, 9'd40, 9'd10};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    peaks_sequencer dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .flush          (flush),
        .fft_valid      (fft_valid),
        .fft_ready      (fft_ready),
        .busy           (busy),
        .pk_strobe      (pk_strobe),
        .pk_reset       (pk_reset),
        .pk_amps        (pk_amps),
        .pk_freqs       (pk_freqs),
        .pk_counter     (pk_counter),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_amps       (out_amps),
        .out_freqs      (out_freqs),
        .out_time       (out_time),
        .frames_dropped (frames_dropped)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_pk_reset", pk_reset, 1);
        chk("rst_fft_ready", fft_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dropped", frames_dropped, 0);
        chk("rst_out_time", out_time, 0);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("rel_pk_reset", pk_reset, 0);
        chk("rel_fft_ready", fft_ready, 1);
        chk("rel_pk_strobe", pk_strobe, 0);
    endtask

    // Called at a negedge with the DUT idle; that cycle is cycle 0.
    // Returns at the negedge of cycle 7 with fft_valid dropped.
    task automatic run_frame(input logic [15:0] ctr, input bit chk_tim, input bit pop_cap);
        pk_counter = ctr;
        fft_valid  = 1'b1;
        chk("accept_ready", fft_ready, 1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLOCK_50);
            if (chk_tim) begin
                chk($sformatf("strobe_c%0d", k), pk_strobe, (k <= 2) ? 1 : 0);
                chk($sformatf("busy_c%0d", k), busy, (k <= 6) ? 1 : 0);
                chk($sformatf("ready_c%0d", k), fft_ready, (k == 7) ? 1 : 0);
            end
            if (pop_cap) out_ready = (k == 6);
        end
        fft_valid = 1'b0;
    endtask

    task automatic drain(input logic [15:0] t0, input logic [15:0] t1,
                         input logic [15:0] t2, input logic [15:0] t3);
        logic [15:0] exp_t [4];
        exp_t[0] = t0; exp_t[1] = t1; exp_t[2] = t2; exp_t[3] = t3;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_valid%0d", i), out_valid, 1);
            chk($sformatf("drain_time%0d", i), out_time, exp_t[i]);
            @(negedge CLOCK_50);
        end
        chk("drain_empty", out_valid, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        fft_valid  = 1'b0;
        out_ready  = 1'b0;
        pk_amps    = AMPS_VEC;
        pk_freqs   = FREQS_VEC;
        pk_counter = '0;

        do_reset();

        // priming frames with full timing check, then the data frame
        run_frame(16'd1, 1'b1, 1'b0);
        chk("prime1_no_out", out_valid, 0);
        run_frame(16'd2, 1'b0, 1'b0);
        chk("prime2_no_out", out_valid, 0);
        run_frame(16'd3, 1'b1, 1'b0);
        chk("data_valid", out_valid, 1);
        chk("data_time", out_time, 1);
        chk("data_freqs", out_freqs, {9'd300, 9'd200, 9'd120, 9'd80, 9'd40, 9'd10});
        chk("data_amps", out_amps, {24'd10, 24'd9, 24'd8, 24'd7, 24'd6, 24'd5});
        repeat (2) @(negedge CLOCK_50);
        chk("hold_time", out_time, 1);
        out_ready = 1'b1;
        @(negedge CLOCK_50);
        out_ready = 1'b0;
        chk("data_popped", out_valid, 0);

        // overflow: 2 primed away, 4 stored, 2 dropped
        do_reset();
        for (int f = 1; f <= 8; f++) run_frame(16'(f), 1'b0, 1'b0);
        chk("ovf_dropped", frames_dropped, 2);
        chk("ovf_head", out_time, 1);

        // full buffer, pop coincides with capture: nothing lost
        run_frame(16'd9, 1'b0, 1'b1);
        out_ready = 1'b0;
        chk("fullpop_dropped", frames_dropped, 2);
        drain(16'd2, 16'd3, 16'd4, 16'd7);

        // flush in the second strobe-high cycle with one result buffered
        run_frame(16'd20, 1'b0, 1'b0);
        chk("preflush_time", out_time, 18);
        pk_counter = 16'd21;
        fft_valid  = 1'b1;
        @(negedge CLOCK_50);
        chk("fl_strobe_c1", pk_strobe, 1);
        @(negedge CLOCK_50);
        chk("fl_strobe_c2", pk_strobe, 1);
        flush = 1'b1;
        @(negedge CLOCK_50);
        flush     = 1'b0;
        fft_valid = 1'b0;
        chk("fl_strobe_off", pk_strobe, 0);
        chk("fl_pk_reset", pk_reset, 1);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_ready_low", fft_ready, 0);
        chk("fl_busy", busy, 0);
        @(negedge CLOCK_50);
        chk("fl_pk_reset_end", pk_reset, 0);
        chk("fl_ready_back", fft_ready, 1);
        chk("fl_dropped_kept", frames_dropped, 2);
        run_frame(16'd1, 1'b0, 1'b0);
        chk("fl_prime1", out_valid, 0);
        run_frame(16'd2, 1'b0, 1'b0);
        chk("fl_prime2", out_valid, 0);
        run_frame(16'd3, 1'b0, 1'b0);
        chk("fl_first_valid", out_valid, 1);
        chk("fl_first_time", out_time, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/peaks_sequencer.md
Name: peaks_sequencer

Overview:
- Sequences FFT frames into the peak detector, which uses its valid_in as a clock and needs a low gap between frames.
- Accepts frames from the FFT, generates a clean strobe with a guaranteed low gap, waits for the detector outputs to settle, then captures them.
- Discards the pipeline-priming results, time-tags each result and buffers it in a small FIFO for the hashing/readout stage, using drop-on-full real-time semantics.

Parameters:
PEAKS, 6, peaks per frame (one per frequency bin)
FREQ_WIDTH, 9, frequency index width
AMPL_WIDTH, 24, final amplitude width
TIME_WIDTH, 16, frame time-tag width
STROBE_HIGH, 2, cycles pk_strobe is held high (>=1)
SETTLE, 3, low cycles after strobe before capture (>=2)
FIFO_DEPTH, 4, result buffer entries (power of 2)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-low reset
flush  in  1  synchronous restart of detector and FIFO, high for 1 cycle
fft_valid  in  1  FFT frame present on detector input bus; upstream holds it stable while busy=1
fft_ready  out  1  frame accepted when fft_valid && fft_ready
busy  out  1  frame in flight (any state other than IDLE)
pk_strobe  out  1  drives detector valid_in, registered
pk_reset  out  1  drives detector reset, active-high, registered
pk_amps  in  PEAKS*AMPL_WIDTH  detector amplitudes, bin 0 in LSBs
pk_freqs  in  PEAKS*FREQ_WIDTH  detector frequencies, bin 0 in LSBs
pk_counter  in  TIME_WIDTH  detector frame counter
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer pop
out_amps  out  PEAKS*AMPL_WIDTH  head amplitudes
out_freqs  out  PEAKS*FREQ_WIDTH  head frequencies
out_time  out  TIME_WIDTH  head center-frame index
frames_dropped  out  16  saturating count of results lost to a full FIFO

Behaviour:
- Reset (reset=0), sampled on the CLOCK_50 edge:
  - State goes to IDLE; FIFO is emptied; prime_cnt=0; frames_dropped=0.
  - pk_strobe=0 and pk_reset=1.
  - Output values during reset: fft_ready=0, busy=0, out_valid=0, out_* = 0.
- Release from reset: pk_reset=0 on the first cycle after reset is seen high.
- FSM: IDLE -> STROBE_HI -> SETTLE -> CAPTURE -> IDLE.
  - IDLE: fft_ready=1. On accept, go to STROBE_HI.
  - STROBE_HI: pk_strobe=1 for STROBE_HIGH cycles.
  - SETTLE: pk_strobe=0 for SETTLE cycles.
  - CAPTURE: 1 cycle; sample pk_* and go to IDLE.
- Timing with defaults, accept at cycle 0:
  - pk_strobe high in cycles 1-2, low from cycle 3.
  - CAPTURE in cycle 6.
  - fft_ready=1 again in cycle 7.
  - out_valid at cycle 7 if the FIFO was empty.
  - Minimum frame period is STROBE_HIGH+SETTLE+2 cycles.
  - The minimum strobe low gap is SETTLE+2 cycles.
- Priming: the detector needs a 3-frame window.
  - Captures while prime_cnt<2 are discarded: no push, no drop count. prime_cnt then increments.
  - Later captures push {pk_amps, pk_freqs, pk_counter-2} modulo 2^TIME_WIDTH.
- FIFO is first-word fall-through. out_valid = !empty; pop on out_valid && out_ready.
  - Push while full with no pop in the same cycle: discard the result and increment frames_dropped, saturating at 16'hFFFF.
  - Push and pop in the same cycle while full: both succeed and nothing is dropped.
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- Flush (reset high): highest priority, applies from any state, including mid-strobe.
  - State -> IDLE; pk_strobe=0 next cycle; pk_reset=1 for exactly the next cycle.
  - FIFO emptied; prime_cnt=0; frames_dropped retained.
  - fft_ready=0 in the flush cycle and in the pk_reset cycle.
- fft_valid asserted outside IDLE is ignored: not accepted, not queued.
- The out_* bus holds its value while out_valid && !out_ready.

Decomposition:
- Package peaks_pkg holds:
  - PEAKS, FREQ_WIDTH, AMPL_WIDTH, TIME_WIDTH.
  - peak_result_t: packed struct {amps, freqs, time}.
  - seq_state_t enum {IDLE, STROBE_HI, SETTLE, CAPTURE}.
- Sub-module peak_result_fifo: synchronous, first-word fall-through, parameterized by depth.
  - Ports: push, pop, din/dout as peak_result_t, full, empty.
  - Behaviour: pop-before-push when full.

Test Plan:
- Reset: hold reset=0 3 cycles -> pk_reset=1, fft_ready=0, out_valid=0, frames_dropped=0. After release: pk_reset=0, fft_ready=1, pk_strobe=0.
- Timing: fft_valid held from cycle 0 -> pk_strobe=1 only in cycles 1-2, busy cycles 1-6, next accept at cycle 7. Frames 1-2 produce no out_valid.
- Data path: frame 3 with pk_counter=3, pk_freqs bins {10,40,80,120,200,300}, amplitudes {5..10} -> out_valid at cycle 7 of that frame, out_time=1, fields match bit-exact.
- Overflow: out_ready=0, feed 8 frames -> FIFO holds times 1,2,3,4 and frames_dropped=2. Then out_ready=1 -> pops in order 1,2,3,4, then out_valid=0.
- Full with simultaneous pop: FIFO full, out_ready=1 during a CAPTURE cycle -> no drop, frames_dropped unchanged, count stays 4.
- Flush: flush in the second STROBE_HI cycle -> pk_strobe=0 next cycle, pk_reset pulses 1 cycle, out_valid=0. The next two frames are discarded; the third yields out_time=1.
